// File: rtl/xadc_drp_responder.sv
// XADC-style DRP responder: register map behind a fixed-latency DRP port plus a conversion stub.
// Optional protocol-error checking is built only when XADC_RESP_ERRCHK_EN is defined.
module xadc_drp_responder #(
  parameter int DRP_LAT       = 4,
  parameter int CONV_CYCLES   = 26,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk200,
  input  logic        rst,
  input  logic        den,
  input  logic        dwe,
  input  logic [6:0]  daddr,
  input  logic [15:0] di,
  output logic        drdy,
  output logic [15:0] do_out,
  input  logic        convst,
  input  logic [11:0] sample_data,
  output logic        busy,
  output logic        eoc,
  output logic        eos,
  output logic [4:0]  channel,
  output logic        err
);

  localparam logic [3:0] LAT_LD    = 4'(DRP_LAT);
  localparam logic [7:0] CONV_LD   = 8'(CONV_CYCLES);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);

  typedef enum logic {DIDLE, DPEND} dstate_t;
  typedef enum logic [1:0] {CIDLE, CONV, SETTLE} cstate_t;

  dstate_t     dstate, dstate_nxt;
  cstate_t     cstate, cstate_nxt;
  logic [3:0]  dcnt;
  logic [7:0]  ccnt;
  logic        lat_we;
  logic [6:0]  lat_addr;
  logic [15:0] lat_di;
  logic [4:0]  conv_ch;
  logic [15:0] cfg0, cfg1, cfg2;
  logic [15:0] res [32];
  logic [15:0] rd_data;
  logic        accept, fire, conv_start, settle_start, conv_done, settle_done;

  // A den coinciding with the drdy cycle is not accepted.
  always_comb begin
    accept       = (dstate == DIDLE) && den && !drdy;
    fire         = (dstate == DPEND) && (dcnt == 4'd1);
    conv_start   = (cstate == CIDLE) && convst && (cfg1[15:12] == 4'b0011);
    settle_start = (cstate == CIDLE) && fire && lat_we && (lat_addr == 7'h40) && !conv_start;
    conv_done    = (cstate == CONV) && (ccnt == 8'd1);
    settle_done  = (cstate == SETTLE) && (ccnt == 8'd1);
    busy         = (cstate != CIDLE);
  end

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      dstate <= DIDLE;
      cstate <= CIDLE;
    end else begin
      dstate <= dstate_nxt;
      cstate <= cstate_nxt;
    end
  end

  always_comb begin
    dstate_nxt = dstate;
    case (dstate)
      DIDLE:   if (accept) dstate_nxt = DPEND;
      DPEND:   if (fire) dstate_nxt = DIDLE;
      default: dstate_nxt = DIDLE;
    endcase
  end

  always_comb begin
    cstate_nxt = cstate;
    case (cstate)
      CIDLE: begin
        if (conv_start)        cstate_nxt = CONV;
        else if (settle_start) cstate_nxt = SETTLE;
      end
      CONV:    if (conv_done) cstate_nxt = CIDLE;
      SETTLE:  if (settle_done) cstate_nxt = CIDLE;
      default: cstate_nxt = CIDLE;
    endcase
  end

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      dcnt     <= '0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_di   <= '0;
    end else if (accept) begin
      dcnt     <= LAT_LD;
      lat_we   <= dwe;
      lat_addr <= daddr;
      lat_di   <= di;
    end else if (dstate == DPEND && !fire) begin
      dcnt <= dcnt - 4'd1;
    end
  end

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      ccnt    <= '0;
      conv_ch <= '0;
    end else if (conv_start) begin
      ccnt    <= CONV_LD;
      conv_ch <= cfg0[4:0];
    end else if (settle_start) begin
      ccnt <= SETTLE_LD;
    end else if (cstate != CIDLE) begin
      ccnt <= ccnt - 8'd1;
    end
  end

  // Read mux forwards a result being written on the same edge.
  always_comb begin
    rd_data = 16'h0000;
    if (lat_addr[6:5] == 2'b00) begin
      if (conv_done && conv_ch == lat_addr[4:0]) rd_data = {sample_data, 4'h0};
      else                                      rd_data = res[lat_addr[4:0]];
    end else begin
      case (lat_addr)
        7'h40:   rd_data = cfg0;
        7'h41:   rd_data = cfg1;
        7'h42:   rd_data = cfg2;
        default: rd_data = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      drdy   <= 1'b0;
      do_out <= '0;
      cfg0   <= 16'h0000;
      cfg1   <= 16'h2000;
      cfg2   <= 16'h0400;
    end else begin
      drdy   <= fire;
      do_out <= fire ? rd_data : 16'h0000;
      if (fire && lat_we) begin
        case (lat_addr)
          7'h40:   cfg0 <= lat_di;
          7'h41:   cfg1 <= lat_di;
          7'h42:   cfg2 <= lat_di;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      eoc     <= 1'b0;
      eos     <= 1'b0;
      channel <= '0;
      for (int i = 0; i < 32; i++) res[i] <= '0;
    end else begin
      eoc <= conv_done;
      eos <= conv_done;
      if (conv_done) begin
        channel      <= conv_ch;
        res[conv_ch] <= {sample_data, 4'h0};
      end
    end
  end

`ifdef XADC_RESP_ERRCHK_EN
  logic err_q;
  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if ((den && dstate == DPEND) || (convst && busy) ||
             (den && dwe && daddr[6:5] == 2'b00)) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Directed bench for xadc_drp_responder with default parameters; outputs sampled on falling edges.
module tb_xadc_drp_responder;
  logic        clk200 = 1'b0;
  logic        rst = 1'b1;
  logic        den = 1'b0, dwe = 1'b0;
  logic [6:0]  daddr = '0;
  logic [15:0] di = '0;
  logic        drdy;
  logic [15:0] do_out;
  logic        convst = 1'b0;
  logic [11:0] sample_data = '0;
  logic        busy, eoc, eos, err;
  logic [4:0]  channel;

  int checks = 0;
  int failures = 0;
  logic [15:0] rd;
  int lat, n, pulses;
  logic err_exp;

  xadc_drp_responder dut (
    .clk200(clk200), .rst(rst), .den(den), .dwe(dwe), .daddr(daddr), .di(di),
    .drdy(drdy), .do_out(do_out), .convst(convst), .sample_data(sample_data),
    .busy(busy), .eoc(eoc), .eos(eos), .channel(channel), .err(err)
  );

  always #5 clk200 = ~clk200;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drp(input logic we, input logic [6:0] a, input logic [15:0] d,
                     output logic [15:0] rdata, output int latency);
    int k;
    @(negedge clk200);
    den = 1'b1; dwe = we; daddr = a; di = d;
    @(negedge clk200);
    den = 1'b0; dwe = 1'b0;
    k = 1;
    while (!drdy && k < 40) begin
      @(negedge clk200);
      k++;
    end
    latency = k - 1;
    rdata = do_out;
  endtask

  task automatic start_conv(input logic [11:0] s);
    @(negedge clk200);
    convst = 1'b1; sample_data = s;
    @(negedge clk200);
    convst = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk200);
      k++;
    end
  endtask

  initial begin
`ifdef XADC_RESP_ERRCHK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    repeat (3) @(negedge clk200);
    chk("rst_drdy", 32'(drdy), 32'h0);
    chk("rst_do", 32'(do_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_eoc_eos", 32'({eoc, eos}), 32'h0);
    chk("rst_channel", 32'(channel), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b0;

    // Reset-value reads and latency
    drp(1'b0, 7'h41, 16'h0, rd, lat);
    chk("cfg1_lat", 32'(lat), 32'd4);
    chk("cfg1_rst", 32'(rd), 32'h2000);
    @(negedge clk200);
    chk("drdy_pulse_width", 32'(drdy), 32'h0);
    chk("do_zero_idle", 32'(do_out), 32'h0);
    drp(1'b0, 7'h42, 16'h0, rd, lat);
    chk("cfg2_rst", 32'(rd), 32'h0400);
    drp(1'b0, 7'h40, 16'h0, rd, lat);
    chk("cfg0_rst", 32'(rd), 32'h0000);
    drp(1'b0, 7'h7F, 16'h0, rd, lat);
    chk("unmapped_rd", 32'(rd), 32'h0000);

    // Configuration writes and settling
    drp(1'b1, 7'h41, 16'h3000, rd, lat);
    chk("cfg1_wr_lat", 32'(lat), 32'd4);
    drp(1'b0, 7'h41, 16'h0, rd, lat);
    chk("cfg1_rb", 32'(rd), 32'h3000);
    drp(1'b1, 7'h40, 16'h0010, rd, lat);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk200);
      n++;
    end
    chk("settle_len", 32'(n), 32'd4);

    // First conversion
    start_conv(12'hABC);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk200);
      n++;
    end
    chk("conv_len", 32'(n), 32'd26);
    chk("eoc_eos", 32'({eoc, eos}), 32'h3);
    chk("channel", 32'(channel), 32'h10);
    @(negedge clk200);
    chk("eoc_width", 32'(eoc), 32'h0);
    drp(1'b0, 7'h10, 16'h0, rd, lat);
    chk("res10", 32'(rd), 32'hABC0);
    drp(1'b0, 7'h11, 16'h0, rd, lat);
    chk("res11_empty", 32'(rd), 32'h0000);

    // den during DPEND and during drdy are ignored
    @(negedge clk200);
    den = 1'b1; dwe = 1'b0; daddr = 7'h41;
    @(negedge clk200);
    den = 1'b0;
    @(negedge clk200);
    den = 1'b1; dwe = 1'b1; daddr = 7'h40; di = 16'h001F;
    @(negedge clk200);
    den = 1'b0; dwe = 1'b0;
    n = 3;
    while (!drdy && n < 40) begin
      @(negedge clk200);
      n++;
    end
    chk("dpend_lat", 32'(n - 1), 32'd4);
    chk("dpend_data", 32'(do_out), 32'h3000);
    den = 1'b1; daddr = 7'h42;
    @(negedge clk200);
    den = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk200);
      if (drdy) pulses++;
    end
    chk("ignored_den_no_drdy", 32'(pulses), 32'd0);
    drp(1'b0, 7'h40, 16'h0, rd, lat);
    chk("cfg0_unchanged", 32'(rd), 32'h0010);

    // convst while busy is ignored
    start_conv(12'h555);
    n = 0;
    while (busy && n < 100) begin
      convst = (n == 5);
      @(negedge clk200);
      n++;
    end
    convst = 1'b0;
    chk("conv_retrig_len", 32'(n), 32'd26);
    chk("err_flag", 32'(err), 32'(err_exp));

    // CFG0 write during CONV applies to next conversion
    start_conv(12'h666);
    drp(1'b1, 7'h40, 16'h0011, rd, lat);
    chk("busy_mid_conv", 32'(busy), 32'h1);
    wait_idle();
    chk("ch_during_wr", 32'(channel), 32'h10);
    chk("eoc_during_wr", 32'(eoc), 32'h1);
    @(negedge clk200);
    chk("no_settle_after_conv", 32'(busy), 32'h0);
    start_conv(12'h777);
    wait_idle();
    chk("ch_next", 32'(channel), 32'h11);
    drp(1'b0, 7'h10, 16'h0, rd, lat);
    chk("res10_after", 32'(rd), 32'h6660);
    drp(1'b0, 7'h11, 16'h0, rd, lat);
    chk("res11_after", 32'(rd), 32'h7770);

    // Reset in the middle of a conversion
    drp(1'b1, 7'h40, 16'h0010, rd, lat);
    wait_idle();
    start_conv(12'h999);
    repeat (9) @(negedge clk200);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk200);
    rst = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk200);
      if (eoc) pulses++;
    end
    chk("abort_no_eoc", 32'(pulses), 32'd0);
    drp(1'b0, 7'h10, 16'h0, rd, lat);
    chk("abort_res10", 32'(rd), 32'h0000);
    drp(1'b0, 7'h41, 16'h0, rd, lat);
    chk("abort_cfg1", 32'(rd), 32'h2000);
    chk("abort_err", 32'(err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
